// File: rtl/button_ctrl.sv
// Push-button front end: two-flop synchroniser, debounce on a shared sample tick,
// press/auto-repeat event generation and lowest-index-first event serialisation.
module button_ctrl #(
    parameter int NUM_BTN      = 4,
    parameter int TICK_MAX     = 249_999,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic               clk_25M,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    output logic [2:0]         evt_id,
    output logic               evt_repeat,
    output logic               tick
);

    localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_MAX);
    localparam logic [HW-1:0] HOLD_PRE    = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);

    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick_q, tick_d;
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] samp_q, samp_d;
    logic [NUM_BTN-1:0] state_q, state_d;
    logic [HW-1:0]      hold_cnt_q [NUM_BTN];
    logic [HW-1:0]      hold_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] rep_q, rep_d;
    logic [NUM_BTN-1:0] pend_set, pend_clr;
    logic               evt_valid_q, evt_valid_d;
    logic [2:0]         evt_id_q, evt_id_d;
    logic               evt_rep_q, evt_rep_d;
    logic               arb_found;

    // tick_q is registered so it is high exactly while the counter holds TICK_MAX
    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
        tick_d     = (tick_cnt_d == TICK_LAST);
    end

    always_comb begin
        samp_d     = samp_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_d      = rep_q;
        pend_set   = '0;
        if (tick_q) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                samp_d[i] = sync2_q[i];
                if (samp_q[i] == sync2_q[i] && sync2_q[i] != state_q[i]) begin
                    state_d[i]    = sync2_q[i];
                    hold_cnt_d[i] = '0;
                    if (sync2_q[i]) begin
                        pend_set[i] = 1'b1;
                        rep_d[i]    = 1'b0;
                    end
                end else if (state_q[i]) begin
                    if (hold_cnt_q[i] == HOLD_PRE) begin
                        pend_set[i]   = 1'b1;
                        rep_d[i]      = 1'b1;
                        hold_cnt_d[i] = HOLD_RELOAD;
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        pend_clr    = '0;
        arb_found   = 1'b0;
        evt_valid_d = 1'b0;
        evt_id_d    = evt_id_q;
        evt_rep_d   = evt_rep_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!arb_found && pend_q[i]) begin
                arb_found   = 1'b1;
                evt_valid_d = 1'b1;
                evt_id_d    = 3'(i);
                evt_rep_d   = rep_q[i];
                pend_clr[i] = 1'b1;
            end
        end
        // a new set wins over a same-edge grant of the same bit
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk_25M or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            tick_q      <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            samp_q      <= '0;
            state_q     <= '0;
            pend_q      <= '0;
            rep_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_rep_q   <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) hold_cnt_q[i] <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            tick_q      <= tick_d;
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            samp_q      <= samp_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
            rep_q       <= rep_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_rep_q   <= evt_rep_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign btn_state  = state_q;
    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign evt_repeat = evt_rep_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with a short tick (10 clocks), HOLD=5, REPEAT=2;
// events are checked in order against a scoreboard queue filled by the stimulus.
module tb_button_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_state;
    logic          evt_valid;
    logic [2:0]    evt_id;
    logic          evt_repeat;
    logic          tick;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    button_ctrl #(
        .NUM_BTN(NB), .TICK_MAX(9), .HOLD_TICKS(5), .REPEAT_TICKS(2)
    ) dut (
        .clk_25M(clk), .reset(rst), .btn_in(btn), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_repeat(evt_repeat), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the falling edge of a tick cycle (reference point N0).
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        chk("tick_wait", tick, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("set_clr_collision", dut.pend_set & dut.pend_clr, 0);
            if (evt_valid) begin
                if (exp_q.size() == 0) chk("evt_unexpected", evt_valid, 1'b0);
                else chk("evt_id_rep", {evt_id, evt_repeat}, exp_q.pop_front());
            end
        end
    end

    initial begin
        bit found;
        int lat;
        bit seen_high;

        // reset and tick cadence
        rst = 1'b1;
        btn = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_btn_state", btn_state, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_id", evt_id, 0);
        chk("rst_evt_repeat", evt_repeat, 0);
        chk("rst_tick", tick, 0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("tick_period", tick, (k % 10 == 9));
        end

        // clean press on button 2
        exp_q.push_back({3'd2, 1'b0});
        btn[2] = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30 && !found; k++) begin
            @(negedge clk);
            if (btn_state[2]) begin
                found = 1'b1;
                lat = k;
            end
        end
        chk("press_latency", (found && lat <= 22), 1'b1);
        @(negedge clk);
        chk("press_evt_valid", evt_valid, 1'b1);
        chk("press_evt_id", evt_id, 2);
        chk("press_evt_repeat", evt_repeat, 1'b0);
        btn[2] = 1'b0;
        repeat (40) @(negedge clk);
        chk("release_state2", btn_state[2], 1'b0);

        // bounce on button 0, phased so no two consecutive ticks sample high
        seen_high = 1'b0;
        wait_tick();
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            seen_high |= btn_state[0];
            if (k == 1) btn[0] = 1'b1;
            else if (k < 40 && (k - 1) % 3 == 0) btn[0] = ~btn[0];
            else if (k == 40) btn[0] = 1'b0;
        end
        chk("bounce_state0", seen_high, 1'b0);

        // auto-repeat on button 1: rise at tick 20, repeats at ticks 70/90/110/130,
        // release sampled low from tick 140 so no repeat at 150
        exp_q.push_back({3'd1, 1'b0});
        repeat (4) exp_q.push_back({3'd1, 1'b1});
        wait_tick();
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            chk("repeat_evt_timing", evt_valid,
                (k == 22 || k == 72 || k == 92 || k == 112 || k == 132));
            if (k == 1) btn[1] = 1'b1;
            if (k == 131) btn[1] = 1'b0;
        end
        chk("repeat_hold_cnt_cleared", dut.hold_cnt_q[1], 0);
        chk("repeat_state1_low", btn_state[1], 1'b0);

        // simultaneous press on buttons 3, 1, 0
        exp_q.push_back({3'd0, 1'b0});
        exp_q.push_back({3'd1, 1'b0});
        exp_q.push_back({3'd3, 1'b0});
        wait_tick();
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            chk("arb_evt_valid", evt_valid, (k >= 22 && k <= 24));
            if (k == 22) chk("arb_first_id", evt_id, 0);
            if (k == 23) chk("arb_second_id", evt_id, 1);
            if (k == 24) chk("arb_third_id", evt_id, 3);
            if (k == 1) btn = 4'b1011;
            if (k == 30) btn = '0;
        end
        chk("arb_states_low", btn_state, 0);

        // reset while button 2 is debounced high and its press is still pending
        wait_tick();
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 1) btn[2] = 1'b1;
        end
        chk("pre_reset_state2", btn_state[2], 1'b1);
        chk("pre_reset_pending2", dut.pend_q[2], 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_state", btn_state, 0);
        chk("async_rst_pending", dut.pend_q, 0);
        chk("async_rst_evt_valid", evt_valid, 1'b0);
        chk("async_rst_tick", tick, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({3'd2, 1'b0});
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("post_reset_evt_timing", evt_valid, (k == 21));
            if (k == 21) chk("post_reset_evt_repeat", evt_repeat, 1'b0);
        end
        btn[2] = 1'b0;
        repeat (40) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
